multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle control FSM for the RV32I subset core: sequences fetch, decode, execute and writeback over several clocks instead of one.
- Drives the instruction-memory handshake, IR/PC/register-file write enables, ALU controls, and imm_src for the immediate sign-extension unit.
- Counts retired instructions.
- Halts with a fault code on an illegal instruction or a fetch timeout.

Parameters:
- RETIRE_WIDTH, 32, width of the retired-instruction counter.
- FETCH_TIMEOUT, 255, maximum cycles to wait for imem_ack before faulting (1..65535).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  current contents of the external instruction register.
- imem_ack  in  1  instruction memory has data valid this cycle.
- alu_zero  in  1  ALU result == 0.
- imem_req  out  1  fetch request to instruction memory.
- ir_write  out  1  load the instruction register this cycle.
- pc_write  out  1  update PC this cycle.
- pc_src  out  1  0: PC+4, 1: PC+imm_ext.
- imm_src  out  1  enable for the immediate sign extender.
- alu_src  out  1  0: rs2 operand, 1: imm_ext operand.
- alu_ctrl  out  3  000 add, 001 sub; all other codes unused.
- reg_write  out  1  register-file write enable.
- halted  out  1  FSM is in HALT.
- fault_code  out  2  00 none, 01 illegal instruction, 10 fetch timeout.
- retired_count  out  RETIRE_WIDTH  number of instructions completed.
- state_dbg  out  3  encoded state, for debug.

Behaviour:
- States and encoding: FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3, HALT=4.
- Reset (synchronous, rst=1 at a clk edge): state=FETCH, retired_count=0, fault_code=00, timeout counter=0.
  - All strobes are low during the reset cycle: imem_req, ir_write, pc_write, reg_write.
  - pc_src=0, imm_src=0, alu_src=0, alu_ctrl=000, halted=0.
  - rst overrides every state, including HALT and mid-fetch.
- All outputs are combinational decodes of the registered state and instr, except retired_count and fault_code, which are registered.
- FETCH:
  - imem_req=1 every cycle in FETCH.
  - imem_ack=1: ir_write=1 in the same cycle, timeout counter cleared, next state DECODE.
  - imem_ack=0: timeout counter increments.
  - If the counter reaches FETCH_TIMEOUT with no ack: fault_code=10, next state HALT.
  - An ack in the same cycle the counter reaches FETCH_TIMEOUT wins; no fault.
- DECODE (1 cycle). Legal instructions:
  - addi: opcode 0010011, funct3 000.
  - add: opcode 0110011, funct3 000, funct7 0000000.
  - sub: opcode 0110011, funct3 000, funct7 0100000.
  - beq: opcode 1100011, funct3 000.
  - bne: opcode 1100011, funct3 001.
  - Any other instruction: fault_code=01, next state HALT, no writes. Otherwise next state EXECUTE.
- imm_src: 1 in DECODE, EXECUTE and WRITEBACK when the opcode is I-type (0010011) or B-type (1100011); 0 otherwise and in all FETCH/HALT cycles.
- ALU controls:
  - alu_src=1 only for addi.
  - alu_ctrl=001 for sub, beq and bne; 000 otherwise.
- EXECUTE:
  - ALU instructions: no strobes, next state WRITEBACK.
  - Branches: pc_write=1 in this cycle; retired_count+1; next state FETCH.
  - Branch taken: beq & alu_zero, or bne & !alu_zero.
  - pc_src=1 when the branch is taken, 0 otherwise.
- WRITEBACK: reg_write=1, pc_write=1, pc_src=0; retired_count+1; next state FETCH.
- retired_count wraps modulo 2^RETIRE_WIDTH with no flag.
- Write enables: at most one pc_write and at most one reg_write per instruction.
- HALT:
  - Terminal until rst.
  - halted=1; all strobes 0; imem_req=0; fault_code held.
  - imem_ack is ignored.
- Instruction latency:
  - ALU instructions: fetch wait + 4 cycles (FETCH-ack, DECODE, EXECUTE, WRITEBACK).
  - Branches: fetch wait + 3 cycles.
- instr must be stable from DECODE until the instruction retires. The FSM does not sample instr in FETCH.

Test Plan:
- Reset, then addi x1,x0,5 (0x00500093) with imem_ack on the first request:
  - state sequence FETCH, DECODE, EXECUTE, WRITEBACK, FETCH.
  - ir_write pulses in cycle 0; imm_src=1 and alu_src=1 in cycles 1-3.
  - reg_write=1 and pc_write=1 with pc_src=0 in cycle 3.
  - retired_count=1.
- bne with alu_zero=0 -> pc_write=1, pc_src=1 in EXECUTE, no reg_write, back to FETCH after 3 cycles.
  - Repeat with alu_zero=1 -> pc_src=0.
  - beq with alu_zero=1 -> pc_src=1.
- sub (funct7=0100000) -> alu_ctrl=001, alu_src=0, imm_src=0.
  - Unsupported opcode 0000011 -> fault_code=01, halted=1 after DECODE.
  - No reg_write or pc_write ever asserted for the faulting instruction.
- FETCH_TIMEOUT=4, imem_ack held at 0:
  - imem_req high for 4 cycles, then HALT with fault_code=10.
  - Ack arriving on exactly the 4th cycle -> normal DECODE, no fault.
- rst asserted mid-EXECUTE and again in HALT:
  - Next cycle state=FETCH, retired_count=0, fault_code=00, no strobes in the reset cycle.
- RETIRE_WIDTH=4, 17 back-to-back addi -> retired_count wraps 15 -> 0 -> 1.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the RV32I subset core: fetch/decode/execute/writeback
// sequencing, retired-instruction counting and halt-on-fault.
module multicycle_control #(
   parameter int RETIRE_WIDTH  = 32,
   parameter int FETCH_TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             instr,
   input  logic                    imem_ack,
   input  logic                    alu_zero,
   output logic                    imem_req,
   output logic                    ir_write,
   output logic                    pc_write,
   output logic                    pc_src,
   output logic                    imm_src,
   output logic                    alu_src,
   output logic [2:0]              alu_ctrl,
   output logic                    reg_write,
   output logic                    halted,
   output logic [1:0]              fault_code,
   output logic [RETIRE_WIDTH-1:0] retired_count,
   output logic [2:0]              state_dbg
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_WRITEBACK = 3'd3,
      S_HALT      = 3'd4
   } state_t;

   localparam logic [6:0]  OP_IMM    = 7'b0010011;
   localparam logic [6:0]  OP_REG    = 7'b0110011;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [15:0] WAIT_LAST = 16'(FETCH_TIMEOUT - 1);

   state_t                  state_reg;
   logic [15:0]             wait_cnt_reg;
   logic [1:0]              fault_reg;
   logic [RETIRE_WIDTH-1:0] retired_reg;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       is_addi, is_add, is_sub, is_beq, is_bne;
   logic       is_branch, is_legal, imm_type, branch_taken;
   logic       unused_instr_bits;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

   assign is_addi   = (opcode == OP_IMM) && (funct3 == 3'b000);
   assign is_add    = (opcode == OP_REG) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
   assign is_sub    = (opcode == OP_REG) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
   assign is_beq    = (opcode == OP_BRANCH) && (funct3 == 3'b000);
   assign is_bne    = (opcode == OP_BRANCH) && (funct3 == 3'b001);
   assign is_branch = is_beq || is_bne;
   assign is_legal  = is_addi || is_add || is_sub || is_branch;
   assign imm_type  = (opcode == OP_IMM) || (opcode == OP_BRANCH);
   assign branch_taken = (is_beq && alu_zero) || (is_bne && !alu_zero);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_FETCH;
         wait_cnt_reg <= 16'd0;
         fault_reg    <= 2'b00;
         retired_reg  <= '0;
      end else begin
         case (state_reg)
            S_FETCH: begin
               // An ack on the final allowed cycle still beats the timeout.
               if (imem_ack) begin
                  wait_cnt_reg <= 16'd0;
                  state_reg    <= S_DECODE;
               end else if (wait_cnt_reg == WAIT_LAST) begin
                  fault_reg <= 2'b10;
                  state_reg <= S_HALT;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 16'd1;
               end
            end
            S_DECODE: begin
               if (is_legal) begin
                  state_reg <= S_EXECUTE;
               end else begin
                  fault_reg <= 2'b01;
                  state_reg <= S_HALT;
               end
            end
            S_EXECUTE: begin
               if (is_branch) begin
                  retired_reg <= retired_reg + RETIRE_WIDTH'(1);
                  state_reg   <= S_FETCH;
               end else begin
                  state_reg <= S_WRITEBACK;
               end
            end
            S_WRITEBACK: begin
               retired_reg <= retired_reg + RETIRE_WIDTH'(1);
               state_reg   <= S_FETCH;
            end
            S_HALT: state_reg <= S_HALT;
            default: state_reg <= S_HALT;
         endcase
      end
   end

   // Control outputs decode the current state and instr; rst forces them quiet.
   always_comb begin
      logic in_instr;
      imem_req  = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      imm_src   = 1'b0;
      alu_src   = 1'b0;
      alu_ctrl  = 3'b000;
      reg_write = 1'b0;
      halted    = 1'b0;
      in_instr  = (state_reg == S_DECODE) || (state_reg == S_EXECUTE) ||
                  (state_reg == S_WRITEBACK);
      if (!rst) begin
         imem_req = (state_reg == S_FETCH);
         ir_write = (state_reg == S_FETCH) && imem_ack;
         halted   = (state_reg == S_HALT);
         if (in_instr) begin
            imm_src  = imm_type;
            alu_src  = is_addi;
            alu_ctrl = (is_sub || is_branch) ? 3'b001 : 3'b000;
         end
         if (state_reg == S_EXECUTE && is_branch) begin
            pc_write = 1'b1;
            pc_src   = branch_taken;
         end
         if (state_reg == S_WRITEBACK) begin
            pc_write  = 1'b1;
            reg_write = 1'b1;
         end
      end
   end

   assign fault_code    = fault_reg;
   assign retired_count = retired_reg;
   assign state_dbg     = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction cycle plans in a queue
// predict every output each cycle, plus directed literal checks.
module tb_multicycle_control;

   localparam int RW = 4;
   localparam int TO = 4;
   localparam logic [31:0] ADDI = 32'h00500093;
   localparam logic [31:0] BNE  = 32'h00209463;
   localparam logic [31:0] SUB  = 32'h402081B3;
   localparam logic [31:0] LW   = 32'h0000A083;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   instr = 32'd0;
   logic          imem_ack = 1'b0;
   logic          alu_zero = 1'b0;
   logic          imem_req, ir_write, pc_write, pc_src, imm_src, alu_src;
   logic [2:0]    alu_ctrl;
   logic          reg_write, halted;
   logic [1:0]    fault_code;
   logic [RW-1:0] retired_count;
   logic [2:0]    state_dbg;

   multicycle_control #(.RETIRE_WIDTH(RW), .FETCH_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .instr(instr), .imem_ack(imem_ack), .alu_zero(alu_zero),
      .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .imm_src(imm_src), .alu_src(alu_src), .alu_ctrl(alu_ctrl), .reg_write(reg_write),
      .halted(halted), .fault_code(fault_code), .retired_count(retired_count),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   // One planned non-fetch cycle of an instruction.
   typedef struct {
      logic [2:0] st;
      logic       imm, asrc;
      logic [2:0] actrl;
      logic       rw, pcw;
      int         br;      // 0 none, 1 beq, 2 bne
      logic       retire;
   } plan_t;

   plan_t         plan_q[$];
   logic [RW-1:0] m_retired = '0;
   logic [1:0]    m_fault   = 2'b00;
   bit            m_halted  = 0;
   bit            m_dec     = 0;
   bit            m_known   = 0;
   int            m_wait    = 0;

   // 0 illegal, 1 addi, 2 add, 3 sub, 4 beq, 5 bne
   function automatic int classify(input logic [31:0] i);
      if (i[14:12] != 3'b000 && !(i[6:0] == 7'b1100011 && i[14:12] == 3'b001)) return 0;
      if (i[6:0] == 7'b0010011) return 1;
      if (i[6:0] == 7'b0110011 && i[31:25] == 7'b0000000) return 2;
      if (i[6:0] == 7'b0110011 && i[31:25] == 7'b0100000) return 3;
      if (i[6:0] == 7'b1100011) return (i[14:12] == 3'b000) ? 4 : 5;
      return 0;
   endfunction

   always @(negedge clk) begin
      logic [2:0] e_st, e_actrl;
      logic e_req, e_irw, e_pcw, e_pcs, e_imm, e_asrc, e_rw, e_halt;
      bit chk_st, chk_regs;
      int kind, path;
      plan_t e, p;
      e_st = 3'd0; e_actrl = 3'd0; e_req = 0; e_irw = 0; e_pcw = 0; e_pcs = 0;
      e_imm = 0; e_asrc = 0; e_rw = 0; e_halt = 0; chk_st = 1; chk_regs = 1;
      kind = 0; path = 0;
      e = '{st: 3'd0, imm: 0, asrc: 0, actrl: 3'd0, rw: 0, pcw: 0, br: 0, retire: 0};
      if (rst) begin
         path = 0; chk_st = 0; chk_regs = m_known;
      end else if (m_halted) begin
         path = 1; e_st = 3'd4; e_halt = 1;
      end else if (plan_q.size() != 0) begin
         path = 2;
         e = plan_q.pop_front();
         e_st = e.st; e_imm = e.imm; e_asrc = e.asrc; e_actrl = e.actrl;
         e_rw = e.rw; e_pcw = e.pcw;
         e_pcs = (e.br == 1) ? alu_zero : (e.br == 2) ? !alu_zero : 1'b0;
      end else if (m_dec) begin
         path = 3;
         kind = classify(instr);
         e_st = 3'd1;
         e_imm = (instr[6:0] == 7'b0010011) || (instr[6:0] == 7'b1100011);
         e_asrc = (kind == 1);
         e_actrl = (kind >= 3) ? 3'd1 : 3'd0;
      end else begin
         path = 4; e_st = 3'd0; e_req = 1; e_irw = imem_ack;
      end

      if (chk_st) chk("state_dbg", 32'(state_dbg), 32'(e_st));
      chk("imem_req", 32'(imem_req), 32'(e_req));
      chk("ir_write", 32'(ir_write), 32'(e_irw));
      chk("pc_write", 32'(pc_write), 32'(e_pcw));
      chk("pc_src", 32'(pc_src), 32'(e_pcs));
      chk("imm_src", 32'(imm_src), 32'(e_imm));
      chk("alu_src", 32'(alu_src), 32'(e_asrc));
      chk("alu_ctrl", 32'(alu_ctrl), 32'(e_actrl));
      chk("reg_write", 32'(reg_write), 32'(e_rw));
      chk("halted", 32'(halted), 32'(e_halt));
      if (chk_regs) begin
         chk("fault_code", 32'(fault_code), 32'(m_fault));
         chk("retired_count", 32'(retired_count), 32'(m_retired));
      end

      case (path)
         0: begin
            m_retired = '0; m_fault = 2'b00; m_halted = 0; m_dec = 0;
            m_wait = 0; m_known = 1; plan_q.delete();
         end
         2: if (e.retire) m_retired = m_retired + 1'b1;
         3: begin
            m_dec = 0;
            if (kind == 0) begin
               m_halted = 1; m_fault = 2'b01;
            end else begin
               p = '{st: 3'd2, imm: e_imm, asrc: e_asrc, actrl: e_actrl, rw: 0,
                     pcw: (kind >= 4), br: (kind == 4) ? 1 : (kind == 5) ? 2 : 0,
                     retire: (kind >= 4)};
               plan_q.push_back(p);
               if (kind <= 3) begin
                  p.st = 3'd3; p.rw = 1; p.pcw = 1; p.br = 0; p.retire = 1;
                  plan_q.push_back(p);
               end
            end
         end
         4: begin
            if (imem_ack) begin
               m_dec = 1; m_wait = 0;
            end else if (m_wait + 1 == TO) begin
               m_halted = 1; m_fault = 2'b10;
            end else begin
               m_wait++;
            end
         end
         default: ;
      endcase
   end

   function automatic logic [31:0] gen_instr();
      logic [31:0] r;
      int k;
      r = $urandom;
      k = $urandom_range(0, 11);
      case (k)
         0, 1, 2: return {r[31:20], r[19:15], 3'b000, r[11:7], 7'b0010011};
         3:       return {7'b0000000, r[24:15], 3'b000, r[11:7], 7'b0110011};
         4:       return {7'b0100000, r[24:15], 3'b000, r[11:7], 7'b0110011};
         5, 6:    return {r[31:15], 3'b000, r[11:7], 7'b1100011};
         7, 8:    return {r[31:15], 3'b001, r[11:7], 7'b1100011};
         9:       return {r[31:7], 7'b0000011};
         10:      return {7'b0000001, r[24:15], 3'b000, r[11:7], 7'b0110011};
         default: return {r[31:15], 3'b100, r[11:7], 7'b1100011};
      endcase
   endfunction

   task automatic step(input logic r, input logic a, input logic z, input logic [31:0] ins);
      @(posedge clk);
      #1;
      rst = r; imem_ack = a; alu_zero = z; instr = ins;
      @(negedge clk);
   endtask

   logic [31:0] cur_ins = 32'd0;

   initial begin
      // addi from reset, then a fetch timeout into HALT
      step(1, 0, 0, $urandom); chk("lit_rst_req", 32'(imem_req), 0);
      chk("lit_rst_retired", 32'(retired_count), 0);
      step(0, 1, 0, $urandom); chk("lit_f_state", 32'(state_dbg), 0);
      chk("lit_f_irw", 32'(ir_write), 1);
      step(0, 0, 0, ADDI);     chk("lit_d_state", 32'(state_dbg), 1);
      chk("lit_d_imm", 32'(imm_src), 1); chk("lit_d_asrc", 32'(alu_src), 1);
      step(0, 0, 0, ADDI);     chk("lit_e_state", 32'(state_dbg), 2);
      chk("lit_e_asrc", 32'(alu_src), 1);
      step(0, 0, 0, ADDI);     chk("lit_w_state", 32'(state_dbg), 3);
      chk("lit_w_rw", 32'(reg_write), 1); chk("lit_w_pcw", 32'(pc_write), 1);
      chk("lit_w_pcs", 32'(pc_src), 0);
      step(0, 0, 0, $urandom); chk("lit_ret1", 32'(retired_count), 1);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, $urandom); chk("lit_to_req", 32'(imem_req), 1);
      end
      step(0, 1, 0, $urandom); chk("lit_to_state", 32'(state_dbg), 4);
      chk("lit_to_fault", 32'(fault_code), 2); chk("lit_to_halt", 32'(halted), 1);
      chk("lit_to_noreq", 32'(imem_req), 0);
      // reset in HALT, then ack on the last allowed fetch cycle
      step(1, 0, 0, $urandom); chk("lit_hrst_halt", 32'(halted), 0);
      step(0, 0, 0, $urandom); chk("lit_hrst_state", 32'(state_dbg), 0);
      chk("lit_hrst_fault", 32'(fault_code), 0); chk("lit_hrst_ret", 32'(retired_count), 0);
      step(0, 0, 0, $urandom);
      step(0, 0, 0, $urandom);
      step(0, 1, 0, $urandom); chk("lit_lastack_irw", 32'(ir_write), 1);
      step(0, 0, 0, BNE);      chk("lit_bne_dec", 32'(state_dbg), 1);
      chk("lit_bne_fault", 32'(fault_code), 0);
      step(0, 0, 0, BNE);      chk("lit_bne_pcw", 32'(pc_write), 1);
      chk("lit_bne_pcs", 32'(pc_src), 1); chk("lit_bne_rw", 32'(reg_write), 0);
      step(0, 1, 0, $urandom); chk("lit_bne_back", 32'(state_dbg), 0);
      chk("lit_bne_ret", 32'(retired_count), 1);
      step(0, 0, 0, SUB);      chk("lit_sub_actrl", 32'(alu_ctrl), 1);
      chk("lit_sub_asrc", 32'(alu_src), 0); chk("lit_sub_imm", 32'(imm_src), 0);
      // reset in EXECUTE of sub
      step(1, 0, 0, SUB);      chk("lit_xrst_pcw", 32'(pc_write), 0);
      chk("lit_xrst_rw", 32'(reg_write), 0);
      step(0, 1, 0, $urandom); chk("lit_xrst_state", 32'(state_dbg), 0);
      chk("lit_xrst_ret", 32'(retired_count), 0);
      step(0, 0, 0, LW);       chk("lit_lw_dec", 32'(state_dbg), 1);
      step(0, 0, 0, LW);       chk("lit_lw_halt", 32'(halted), 1);
      chk("lit_lw_fault", 32'(fault_code), 1);
      // 17 back-to-back addi wrap the 4-bit counter to 1
      step(1, 0, 0, ADDI);
      for (int i = 0; i < 69; i++) step(0, 1, 0, ADDI);
      chk("lit_wrap_ret", 32'(retired_count), 1);

      // randomized phase
      for (int c = 0; c < 4000; c++) begin
         logic r;
         @(posedge clk);
         #1;
         r = (m_halted && $urandom_range(0, 2) == 0) || ($urandom_range(0, 59) == 0);
         if (m_dec) cur_ins = gen_instr();
         rst = r;
         imem_ack = ($urandom_range(0, 9) < 7);
         alu_zero = $urandom_range(0, 1) == 1;
         instr = (m_dec || plan_q.size() != 0) ? cur_ins : $urandom;
      end
      @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
